// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the digit-serial subtractor.
// The saturation build is selected with the SERIAL_SUB_SAT_EN macro.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;

endpackage

// File: rtl/serial_sub_fullsub_digit.sv
// Combinational DIGIT-bit subtract slice: {bo, d} = x - y - bi at DIGIT+1 bits.
module fullsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] r;

  assign r  = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  assign d  = r[DIGIT-1:0];
  assign bo = r[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per cycle, LSB slice first.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero when the final borrow is set.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       state_dbg
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(K) + 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0]       slice_d;
  logic                   slice_bo;
  logic [WIDTH+DIGIT-1:0] acc_ext;
  logic [WIDTH-1:0]       acc_nx;
  logic [WIDTH-1:0]       result;

  fullsub_digit #(.DIGIT(DIGIT)) u_slice (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .bi (borrow_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // New slice enters at the top; after K cycles the LSB slice has reached bit 0.
  assign acc_ext = {slice_d, acc_q};
  assign acc_nx  = acc_ext[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_SUB_SAT_EN
  assign result = slice_bo ? '0 : acc_nx;
`else
  assign result = acc_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is accepted only in IDLE; done is a one-cycle pulse with diff/bout valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    diff      = diff_q;
    bout      = bout_q;
    state_dbg = state_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        acc_d    = acc_nx;
        borrow_d = slice_bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d = result;
          bout_d = slice_bo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: W8/D1, W8/D4 and W1/D1 instances on a shared clock and reset.
module tb_serial_sub;
  import serial_sub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       st0, bin0, busy0, done0, bout0;
  logic [7:0] a0, b0, diff0;
  logic [1:0] dbg0;

  logic       st1, bin1, busy1, done1, bout1;
  logic [7:0] a1, b1, diff1;
  logic [1:0] dbg1;

  logic       st2, bin2, busy2, done2, bout2;
  logic [0:0] a2, b2, diff2;
  logic [1:0] dbg2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_diff[3];
  logic       last_bout[3];

  serial_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .bin(bin0),
    .busy(busy0), .done(done0), .diff(diff0), .bout(bout0), .state_dbg(dbg0)
  );

  serial_sub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .state_dbg(dbg1)
  );

  serial_sub #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .state_dbg(dbg2)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [7:0] get_diff(input int sel);
    case (sel)
      0: return diff0;
      1: return diff1;
      default: return {7'd0, diff2};
    endcase
  endfunction

  function automatic logic get_bout(input int sel);
    case (sel)
      0: return bout0;
      1: return bout1;
      default: return bout2;
    endcase
  endfunction

  function automatic logic [1:0] get_dbg(input int sel);
    case (sel)
      0: return dbg0;
      1: return dbg1;
      default: return dbg2;
    endcase
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] d, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
    return bo ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input logic s);
    case (sel)
      0: begin a0 = a; b0 = b; bin0 = bi; st0 = s; end
      1: begin a1 = a; b1 = b; bin1 = bi; st1 = s; end
      default: begin a2 = a[0]; b2 = b[0]; bin2 = bi; st2 = s; end
    endcase
  endtask

  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input int k, input logic [7:0] ed,
                        input logic eb, input string tag);
    int nb;
    logic [7:0] exp;
    @(negedge clk);
    drive(sel, a, b, bi, 1'b1);
    exp_q.push_back(sat(ed, eb));
    @(negedge clk);
    drive(sel, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    nb = 0;
    while (get_busy(sel) && nb < 100) begin
      nb++;
      if (nb == 1) chk({tag, "_hold"}, get_diff(sel), last_diff[sel]);
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, nb, k);
    chk({tag, "_done"}, get_done(sel), 1'b1);
    exp = exp_q.pop_front();
    chk({tag, "_diff"}, get_diff(sel), exp);
    chk({tag, "_bout"}, get_bout(sel), eb);
    last_diff[sel] = exp;
    last_bout[sel] = eb;
    @(negedge clk);
    chk({tag, "_done_clr"}, get_done(sel), 1'b0);
    chk({tag, "_idle"}, get_dbg(sel), IDLE);
  endtask

  task automatic check_reset(input string tag);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("%s%0d_state", tag, s), get_dbg(s), IDLE);
      chk($sformatf("%s%0d_busy", tag, s), get_busy(s), 1'b0);
      chk($sformatf("%s%0d_done", tag, s), get_done(s), 1'b0);
      chk($sformatf("%s%0d_diff", tag, s), get_diff(s), 8'h00);
      chk($sformatf("%s%0d_bout", tag, s), get_bout(s), 1'b0);
      last_diff[s] = 8'h00;
      last_bout[s] = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] tt_d;
    logic [7:0] tt_b;
    int nd;
    logic [7:0] dseen;
    logic       bseen;
    logic [2:0] v;

    for (int s = 0; s < 3; s++) drive(s, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // W8/D1 directed vectors
    run_op(0, 8'h05, 8'h03, 1'b0, 8, 8'h02, 1'b0, "w8d1_05m03");
    run_op(0, 8'h03, 8'h05, 1'b1, 8, 8'hFD, 1'b1, "w8d1_03m05b");
    run_op(0, 8'h80, 8'h7F, 1'b0, 8, 8'h01, 1'b0, "w8d1_80m7f");
    run_op(0, 8'h00, 8'h00, 1'b1, 8, 8'hFF, 1'b1, "w8d1_00m00b");
    run_op(0, 8'hFF, 8'h00, 1'b1, 8, 8'hFE, 1'b0, "w8d1_ffm00b");

    // W8/D4 directed vectors
    run_op(1, 8'hA0, 8'h0F, 1'b0, 2, 8'h91, 1'b0, "w8d4_a0m0f");
    run_op(1, 8'h10, 8'h20, 1'b0, 2, 8'hF0, 1'b1, "w8d4_10m20");
    run_op(1, 8'hFF, 8'hFF, 1'b1, 2, 8'hFF, 1'b1, "w8d4_ffmffb");

    // W1/D1 full-subtractor truth table, index = {a, b, bin}
    tt_d = 8'h96;
    tt_b = 8'h8E;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run_op(2, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1, {7'd0, tt_d[i]}, tt_b[i],
             $sformatf("w1_tt%0d", i));
    end

    // start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    drive(0, 8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 8'h10, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 8'h10, 8'h01, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 8'h10, 8'h01, 1'b1, 1'b0);
    nd = 0;
    dseen = 8'h00;
    bseen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done0) begin
        nd++;
        dseen = diff0;
        bseen = bout0;
      end
      @(negedge clk);
    end
    chk("ignore_start_ndone", nd, 1);
    chk("ignore_start_diff", dseen, 8'h02);
    chk("ignore_start_bout", bseen, 1'b0);
    last_diff[0] = 8'h02;

    // reset during the third RUN cycle aborts the operation
    @(negedge clk);
    drive(0, 8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 8'h05, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", busy0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("abort");
    drive(0, 8'h09, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 8'h09, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("start_with_rst_busy", busy0, 1'b0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);

    // normal operation resumes after reset
    run_op(0, 8'h05, 8'h03, 1'b0, 8, 8'h02, 1'b0, "post_rst_w8d1");
    run_op(1, 8'h33, 8'h11, 1'b0, 2, 8'h22, 1'b0, "post_rst_w8d4");

    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
